// File: rtl/icb_osram_wb_pkg.sv
// ---------------------------------------------------------------------------
// mhsa_wb_pkg
// Shared types and constants for the osram write-back ICB initiator.
//   wb_state_t      : write-back FSM states
//   BYTES_PER_WORD  : byte stride of one osram word in system memory
//   ICB_WMASK_FULL  : byte mask for full 32-bit ICB writes
//   word_byte_addr(): destination byte address of the low/high half of a word
// ---------------------------------------------------------------------------
package mhsa_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    LO,
    HI,
    DRAIN,
    FIN
  } wb_state_t;

  localparam int         BYTES_PER_WORD = 8;
  localparam logic [3:0] ICB_WMASK_FULL = 4'hF;

  // 32-bit modulo arithmetic: wrapping past 32'hFFFF_FFFF is intentional.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [15:0] idx,
                                                 input logic        hi_half);
    return base + (32'(idx) * 32'(BYTES_PER_WORD)) + (hi_half ? 32'd4 : 32'd0);
  endfunction

endpackage

// File: rtl/icb_osram_wb_if.sv
// ---------------------------------------------------------------------------
// icb_osram_wb_if
// ICB command/response channel bundle.
//   master modport : drives cmd_valid/read/addr/wdata/wmask and rsp_ready
//   slave modport  : drives cmd_ready and rsp_valid/rdata/err
// ---------------------------------------------------------------------------
interface icb_osram_wb_if;

  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

endinterface

// File: rtl/icb_osram_wb.sv
// ---------------------------------------------------------------------------
// icb_osram_wb
// Reads word_cnt 64-bit words from the output SRAM and writes each one to
// system memory as two 32-bit ICB writes (low half first) at
// output_base + 8*i and output_base + 8*i + 4. Tracks outstanding write
// responses and pulses done once all of them have returned.
//
// Parameters: OSRAM_AW (osram word-address width, <= 16),
//             MAX_OST  (max commands awaiting response, power of 2, >= 2)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               start pulse, ignored while busy
//   output_base         8-byte aligned destination base (sampled on start)
//   word_cnt            number of 64-bit words (sampled on start)
//   busy, done, err     status: busy, one-cycle done, sticky response error
//   osram_addr/rd_en    osram read port (data one cycle after rd_en)
//   osram_rdata         osram read data
//   icb                 ICB master port (icb_osram_wb_if.master)
//
// Build option: define WB_ERR_ABORT_EN to stop issuing new commands after the
// first response error; the transfer then drains and finishes with err set.
// ---------------------------------------------------------------------------
module icb_osram_wb
  import mhsa_wb_pkg::*;
#(
  parameter int OSRAM_AW = 16,
  parameter int MAX_OST  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         output_base,
  input  logic [15:0]         word_cnt,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [OSRAM_AW-1:0] osram_addr,
  output logic                osram_rd_en,
  input  logic [63:0]         osram_rdata,
  icb_osram_wb_if.master      icb
);

  localparam int               OST_W    = $clog2(MAX_OST) + 1;
  localparam logic [OST_W-1:0] OST_FULL = OST_W'(MAX_OST);

  wb_state_t        state_reg, state_next;
  logic [31:0]      base_reg;
  logic [15:0]      cnt_reg;
  logic [15:0]      idx_reg;
  logic [63:0]      hold_reg;
  logic [OST_W-1:0] ost_reg;
  logic             err_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             start_acc;
  logic             cmd_hs;
  logic             rsp_hs;
  logic             ost_full;
  logic             issue_ok;
  logic             abort_now;
  logic             cmd_valid;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic             rd_en;
  logic             unused_rsp_rdata;

  assign start_acc = (state_reg == IDLE) && start;
  assign cmd_hs    = cmd_valid && icb.icb_cmd_ready;
  assign rsp_hs    = icb.icb_rsp_valid && icb.icb_rsp_ready;
  assign ost_full  = (ost_reg == OST_FULL);

`ifdef WB_ERR_ABORT_EN
  // Remembers that a command is currently presented without a handshake, so an
  // error arriving meanwhile cannot retract it.
  logic cmd_wait_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wait_reg <= 1'b0;
    end else begin
      cmd_wait_reg <= cmd_valid && !icb.icb_cmd_ready;
    end
  end

  assign issue_ok  = !err_reg || cmd_wait_reg;
  assign abort_now = err_reg && !cmd_wait_reg;
`else
  assign issue_ok  = 1'b1;
  assign abort_now = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and command/read outputs
  always_comb begin
    state_next = state_reg;
    cmd_valid  = 1'b0;
    rd_en      = 1'b0;
    cmd_addr   = word_byte_addr(base_reg, idx_reg, 1'b0);
    cmd_wdata  = hold_reg[31:0];
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (word_cnt == 16'd0) ? FIN : RD;
        end
      end
      RD: begin
        rd_en      = 1'b1;
        state_next = LAT;
      end
      LAT: begin
        state_next = LO;
      end
      LO: begin
        // Valid only rises when a response slot is free, so once up it stays
        // up until accepted (the count cannot grow without a handshake).
        cmd_valid = !ost_full && issue_ok;
        if (abort_now) begin
          state_next = DRAIN;
        end else if (cmd_valid && icb.icb_cmd_ready) begin
          state_next = HI;
        end
      end
      HI: begin
        cmd_addr  = word_byte_addr(base_reg, idx_reg, 1'b1);
        cmd_wdata = hold_reg[63:32];
        cmd_valid = !ost_full && issue_ok;
        if (abort_now) begin
          state_next = DRAIN;
        end else if (cmd_valid && icb.icb_cmd_ready) begin
          state_next = (idx_reg == cnt_reg - 16'd1) ? DRAIN : RD;
        end
      end
      DRAIN: begin
        if (ost_reg == '0) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath, outstanding counter and status
  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg <= '0;
      cnt_reg  <= '0;
      idx_reg  <= '0;
      hold_reg <= '0;
      ost_reg  <= '0;
      err_reg  <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIN);

      if (start_acc) begin
        base_reg <= output_base;
        cnt_reg  <= word_cnt;
        idx_reg  <= '0;
        busy_reg <= 1'b1;
      end else if (state_reg == FIN) begin
        busy_reg <= 1'b0;
      end

      if (state_reg == LAT) begin
        hold_reg <= osram_rdata;
      end

      if ((state_reg == HI) && cmd_hs) begin
        idx_reg <= idx_reg + 16'd1;
      end

      // A response with nothing outstanding is dropped rather than underflowing.
      unique case ({cmd_hs, rsp_hs && (ost_reg != '0)})
        2'b10:   ost_reg <= ost_reg + 1'b1;
        2'b01:   ost_reg <= ost_reg - 1'b1;
        default: ost_reg <= ost_reg;
      endcase

      if (rsp_hs && icb.icb_rsp_err) begin
        err_reg <= 1'b1;
      end else if (start_acc) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign busy             = busy_reg;
  assign done             = done_reg;
  assign err              = err_reg;
  assign osram_addr       = OSRAM_AW'(idx_reg);
  assign osram_rd_en      = rd_en;
  assign icb.icb_cmd_valid = cmd_valid;
  assign icb.icb_cmd_read  = 1'b0;
  assign icb.icb_cmd_addr  = cmd_addr;
  assign icb.icb_cmd_wdata = cmd_wdata;
  assign icb.icb_cmd_wmask = ICB_WMASK_FULL;
  assign icb.icb_rsp_ready = !rst;

  // Write responses carry no data of interest.
  assign unused_rsp_rdata = ^icb.icb_rsp_rdata;

endmodule

// File: tb/tb_icb_osram_wb.sv
// ---------------------------------------------------------------------------
// tb_icb_osram_wb
// Bench for icb_osram_wb: osram model, ICB slave with one-cycle response
// latency (optionally withheld / error-injecting), write scoreboard.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_icb_osram_wb;
  import mhsa_wb_pkg::*;

  localparam int MAX_OST = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] output_base = '0;
  logic [15:0] word_cnt = '0;
  logic        busy, done, err;
  logic [15:0] osram_addr;
  logic        osram_rd_en;
  logic [63:0] osram_rdata;

  icb_osram_wb_if icb_bus();

  icb_osram_wb #(.OSRAM_AW(16), .MAX_OST(MAX_OST)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .output_base (output_base),
    .word_cnt    (word_cnt),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .osram_addr  (osram_addr),
    .osram_rd_en (osram_rd_en),
    .osram_rdata (osram_rdata),
    .icb         (icb_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // osram model: registered read
  logic [63:0] mem [0:15];
  always @(posedge clk) begin
    if (osram_rd_en) osram_rdata <= mem[osram_addr[3:0]];
  end

  // ICB slave / monitor, evaluated mid-cycle
  logic        rsp_hold = 1'b0;
  int          err_nth = 0;
  int          pend = 0;
  int          rsp_idx = 0;
  int          obs_wr = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          vld_cnt = 0;
  logic [15:0] last_rd_addr = '0;
  logic [31:0] obs_a [0:255];
  logic [31:0] obs_d [0:255];

  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      icb_bus.icb_rsp_valid = 1'b0;
      icb_bus.icb_rsp_err   = 1'b0;
    end else begin
      if (pend > 0 && !rsp_hold) begin
        icb_bus.icb_rsp_valid = 1'b1;
        icb_bus.icb_rsp_err   = (rsp_idx + 1 == err_nth);
        rsp_idx++;
        pend--;
      end else begin
        icb_bus.icb_rsp_valid = 1'b0;
        icb_bus.icb_rsp_err   = 1'b0;
      end
      if (icb_bus.icb_cmd_valid) vld_cnt++;
      if (icb_bus.icb_cmd_valid && icb_bus.icb_cmd_ready && obs_wr < 256) begin
        obs_a[obs_wr] = icb_bus.icb_cmd_addr;
        obs_d[obs_wr] = icb_bus.icb_cmd_wdata;
        obs_wr++;
        pend++;
      end
      if (done) done_cnt++;
      if (osram_rd_en) begin
        rd_cnt++;
        last_rd_addr = osram_addr;
      end
    end
  end

  wr_t exp_q[$];
  int  obs_rd = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] base, input int cnt);
    wr_t e;
    for (int i = 0; i < cnt; i++) begin
      e.a = base + 32'(i) * 32'd8;
      e.d = mem[i][31:0];
      exp_q.push_back(e);
      e.a = e.a + 32'd4;
      e.d = mem[i][63:32];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
    output_base = base;
    word_cnt    = cnt;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int snap, output logic ok);
    for (int i = 0; i < budget && done_cnt == snap; i++) tick();
    ok = (done_cnt != snap);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({busy, done, err, osram_rd_en, icb_bus.icb_cmd_valid, icb_bus.icb_rsp_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000", {busy, done, err, osram_rd_en, icb_bus.icb_cmd_valid, icb_bus.icb_rsp_ready});
    end
    checks++;
    if ({osram_addr, icb_bus.icb_cmd_addr, icb_bus.icb_cmd_wdata} !== 80'd0) begin
      failures++;
      $display("FAIL reset_buses got=%h/%h/%h exp=0", osram_addr, icb_bus.icb_cmd_addr, icb_bus.icb_cmd_wdata);
    end
    checks++;
    if (icb_bus.icb_cmd_wmask !== 4'hF || icb_bus.icb_cmd_read !== 1'b0) begin
      failures++;
      $display("FAIL reset_wmask got=%h read=%b exp=f read=0", icb_bus.icb_cmd_wmask, icb_bus.icb_cmd_read);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (icb_bus.icb_rsp_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_rsp_ready got=%b exp=1", icb_bus.icb_rsp_ready);
    end
    $display("reset done");
  endtask

  task automatic test_basic();
    int snap = done_cnt;
    logic ok;
    wr_t e;
    push_exp(32'h8000_0000, 2);
    do_start(32'h8000_0000, 16'd2);
    wait_done(200, snap, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    checks++;
    if (obs_wr - obs_rd !== exp_q.size()) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=%0d", obs_wr - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr || obs_a[obs_rd] !== e.a || obs_d[obs_rd] !== e.d) begin
        failures++;
        $display("FAIL basic_write got=%h:%h exp=%h:%h", obs_a[obs_rd], obs_d[obs_rd], e.a, e.d);
      end
      $display("basic write addr=%h data=%h", e.a, e.d);
      obs_rd++;
    end
    repeat (4) tick();
    checks++;
    if (done_cnt - snap !== 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_err got=%0d/%b exp=1/0", done_cnt - snap, err);
    end
    checks++;
    if (last_rd_addr !== 16'd1) begin
      failures++;
      $display("FAIL basic_last_rd_addr got=%0d exp=1", last_rd_addr);
    end
  endtask

  task automatic test_zero();
    int v0 = vld_cnt;
    int r0 = rd_cnt;
    do_start(32'h4000_0000, 16'd0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_cycle1 got=done%b busy%b exp=done0 busy1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_cycle2 got=done%b busy%b exp=done1 busy0", done, busy);
    end
    repeat (3) tick();
    checks++;
    if (vld_cnt !== v0 || rd_cnt !== r0) begin
      failures++;
      $display("FAIL zero_activity got=vld%0d rd%0d exp=vld%0d rd%0d", vld_cnt, rd_cnt, v0, r0);
    end
    $display("zero-count transfer done");
  endtask

  task automatic test_ost();
    int snap = done_cnt;
    logic ok;
    wr_t e;
    rsp_hold = 1'b1;
    push_exp(32'h0000_1000, 4);
    do_start(32'h0000_1000, 16'd4);
    repeat (30) tick();
    checks++;
    if (obs_wr - obs_rd !== MAX_OST) begin
      failures++;
      $display("FAIL ost_limit got=%0d exp=%0d", obs_wr - obs_rd, MAX_OST);
    end
    checks++;
    if (icb_bus.icb_cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL ost_valid_low got=%b exp=0", icb_bus.icb_cmd_valid);
    end
    rsp_hold = 1'b0;
    wait_done(300, snap, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL ost_done_timeout got=0 exp=1"); end
    checks++;
    if (obs_wr - obs_rd !== exp_q.size()) begin
      failures++;
      $display("FAIL ost_count got=%0d exp=%0d", obs_wr - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr || obs_a[obs_rd] !== e.a || obs_d[obs_rd] !== e.d) begin
        failures++;
        $display("FAIL ost_write got=%h:%h exp=%h:%h", obs_a[obs_rd], obs_d[obs_rd], e.a, e.d);
      end
      $display("ost write addr=%h data=%h", e.a, e.d);
      obs_rd++;
    end
    repeat (4) tick();
    checks++;
    if (done_cnt - snap !== 1) begin
      failures++;
      $display("FAIL ost_done_once got=%0d exp=1", done_cnt - snap);
    end
  endtask

  task automatic test_stall();
    int snap = done_cnt;
    logic ok;
    logic [31:0] a0, d0;
    wr_t e;
    icb_bus.icb_cmd_ready = 1'b0;
    push_exp(32'h1000_0040, 2);
    do_start(32'h1000_0040, 16'd2);
    for (int i = 0; i < 20 && !icb_bus.icb_cmd_valid; i++) tick();
    checks++;
    if (icb_bus.icb_cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_valid_rise got=0 exp=1");
    end
    a0 = icb_bus.icb_cmd_addr;
    d0 = icb_bus.icb_cmd_wdata;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        output_base = 32'hDEAD_0000;
        word_cnt    = 16'd0;
        start       = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      checks++;
      if (icb_bus.icb_cmd_valid !== 1'b1 || icb_bus.icb_cmd_addr !== a0 || icb_bus.icb_cmd_wdata !== d0) begin
        failures++;
        $display("FAIL stall_hold got=%b:%h:%h exp=1:%h:%h", icb_bus.icb_cmd_valid,
                 icb_bus.icb_cmd_addr, icb_bus.icb_cmd_wdata, a0, d0);
      end
    end
    start = 1'b0;
    icb_bus.icb_cmd_ready = 1'b1;
    wait_done(200, snap, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL stall_done_timeout got=0 exp=1"); end
    checks++;
    if (obs_wr - obs_rd !== exp_q.size()) begin
      failures++;
      $display("FAIL stall_count got=%0d exp=%0d", obs_wr - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr || obs_a[obs_rd] !== e.a || obs_d[obs_rd] !== e.d) begin
        failures++;
        $display("FAIL stall_write got=%h:%h exp=%h:%h", obs_a[obs_rd], obs_d[obs_rd], e.a, e.d);
      end
      $display("stall write addr=%h data=%h", e.a, e.d);
      obs_rd++;
    end
    repeat (5) tick();
    checks++;
    if (done_cnt - snap !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_ignored_start got=%0d/%b exp=1/0", done_cnt - snap, busy);
    end
  endtask

  task automatic test_err();
    int snap = done_cnt;
    int n;
    logic ok;
    wr_t e;
    err_nth = rsp_idx + 2;
    push_exp(32'h0000_2000, 3);
    do_start(32'h0000_2000, 16'd3);
    wait_done(300, snap, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL err_done_timeout got=0 exp=1"); end
    n = obs_wr - obs_rd;
`ifdef WB_ERR_ABORT_EN
    checks++;
    if (n < 2 || n > 2 + MAX_OST) begin
      failures++;
      $display("FAIL err_abort_count got=%0d exp=2..%0d", n, 2 + MAX_OST);
    end
`else
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL err_count got=%0d exp=6", n);
    end
`endif
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_a[obs_rd] !== e.a || obs_d[obs_rd] !== e.d) begin
        failures++;
        $display("FAIL err_write got=%h:%h exp=%h:%h", obs_a[obs_rd], obs_d[obs_rd], e.a, e.d);
      end
      $display("err write addr=%h data=%h", e.a, e.d);
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_wr;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
    err_nth = 0;
    repeat (4) tick();
  endtask

  task automatic test_rst_mid();
    int snap = done_cnt;
    logic found = 1'b0;
    do_start(32'h2000_0000, 16'd4);
    for (int i = 0; i < 50 && !found; i++) begin
      if (icb_bus.icb_cmd_valid && icb_bus.icb_cmd_addr[2]) found = 1'b1;
      else tick();
    end
    checks++;
    if (found !== 1'b1) begin failures++; $display("FAIL rst_mid_reach_hi got=0 exp=1"); end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, err, osram_rd_en, icb_bus.icb_cmd_valid, icb_bus.icb_rsp_ready} !== 6'b0 ||
        {osram_addr, icb_bus.icb_cmd_addr, icb_bus.icb_cmd_wdata} !== 80'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b %h %h %h exp=000000 0 0 0",
               {busy, done, err, osram_rd_en, icb_bus.icb_cmd_valid, icb_bus.icb_rsp_ready},
               osram_addr, icb_bus.icb_cmd_addr, icb_bus.icb_cmd_wdata);
    end
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (done_cnt !== snap || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_no_done got=%0d/%b exp=%0d/0", done_cnt, busy, snap);
    end
    obs_rd = obs_wr;
    $display("reset mid-transfer done");
  endtask

  task automatic test_restart();
    int snap = done_cnt;
    logic ok;
    wr_t e;
    mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    mem[1] = 64'h0123_4567_89AB_CDEF;
    push_exp(32'hFFFF_FFF8, 2);
    do_start(32'hFFFF_FFF8, 16'd2);
    wait_done(200, snap, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL restart_done_timeout got=0 exp=1"); end
    checks++;
    if (obs_wr - obs_rd !== exp_q.size()) begin
      failures++;
      $display("FAIL restart_count got=%0d exp=%0d", obs_wr - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr || obs_a[obs_rd] !== e.a || obs_d[obs_rd] !== e.d) begin
        failures++;
        $display("FAIL restart_write got=%h:%h exp=%h:%h", obs_a[obs_rd], obs_d[obs_rd], e.a, e.d);
      end
      $display("restart write addr=%h data=%h", e.a, e.d);
      obs_rd++;
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL restart_err_cleared got=%b exp=0", err);
    end
  endtask

  initial begin
    icb_bus.icb_cmd_ready = 1'b1;
    icb_bus.icb_rsp_rdata = '0;
    icb_bus.icb_rsp_valid = 1'b0;
    icb_bus.icb_rsp_err   = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = {32'(i) * 32'h0101_0101, ~(32'(i) * 32'h0202_0202)};
    mem[0] = 64'h1111_2222_3333_4444;
    mem[1] = 64'h5555_6666_7777_8888;
    test_reset();
    test_basic();
    test_zero();
    test_ost();
    test_stall();
    test_err();
    test_rst_mid();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icb_osram_wb.md
Name: icb_osram_wb

Overview:
- ICB initiator that writes MHSA result data back to system memory. It is the master-side counterpart of the accelerator's ICB slave/usram write path.
- On start, it reads word_cnt 64-bit words from the output SRAM (osram) and splits each into two 32-bit ICB write commands, low half first, to output_base + 8*i and output_base + 8*i + 4.
- It tracks outstanding responses and signals done once every response has returned.

Parameters:
- OSRAM_AW, 16, osram word-address width.
- MAX_OST, 4, maximum ICB write commands awaiting response (power of 2, >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle start pulse; ignored while busy.
- output_base  in  32  byte base address of destination; must be 8-byte aligned; sampled on accepted start.
- word_cnt  in  16  number of 64-bit words to write; sampled on accepted start.
- busy  out  1  high from accepted start until done pulse.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky; set by any icb_rsp_err, cleared on accepted start.
- osram_addr  out  OSRAM_AW  osram word address.
- osram_rd_en  out  1  osram read strobe; data valid on osram_rdata one cycle later.
- osram_rdata  in  64  osram read data.
- icb_cmd_valid  out  1  ICB command valid.
- icb_cmd_ready  in  1  ICB command ready.
- icb_cmd_read  out  1  constant 0.
- icb_cmd_addr  out  32  write byte address.
- icb_cmd_wdata  out  32  write data.
- icb_cmd_wmask  out  4  constant 4'hF.
- icb_rsp_valid  in  1  response valid.
- icb_rsp_ready  out  1  response ready.
- icb_rsp_rdata  in  32  unused.
- icb_rsp_err  in  1  response error.

Behaviour:
- Reset: every output 0 except icb_cmd_wmask = 4'hF; FSM returns to IDLE; outstanding count cleared. Reset mid-transfer aborts the transfer with no done pulse.
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- icb_rsp_ready = 1 whenever not in reset.
- FSM states: IDLE, RD, LAT, LO, HI, DRAIN, FIN.
- IDLE:
  - start -> latch base and count, clear idx and err, busy = 1.
  - If word_cnt == 0 -> FIN; otherwise -> RD.
- RD:
  - osram_rd_en = 1 for exactly one cycle, osram_addr = idx -> LAT.
- LAT:
  - Capture osram_rdata into a 64-bit holding register -> LO.
- LO:
  - icb_cmd_valid = 1, addr = base + {idx, 3'b000}, wdata = hold[31:0].
  - Handshake (valid & ready) -> HI.
- HI:
  - Same as LO with addr + 4 and wdata = hold[63:32].
  - On handshake: idx++; if idx == cnt-1 -> DRAIN, else -> RD.
- DRAIN:
  - Wait for outstanding == 0 -> FIN.
- FIN:
  - done = 1 for one cycle, busy = 0 -> IDLE.
- ICB command rules:
  - Once icb_cmd_valid is asserted, addr and wdata hold stable until the handshake.
  - icb_cmd_valid is never dropped without a handshake.
  - icb_cmd_valid is not asserted in LO/HI while outstanding == MAX_OST.
- Outstanding counter:
  - +1 on command handshake, -1 on response handshake; a simultaneous command and response leaves it unchanged.
  - A response while outstanding == 0 is ignored; no underflow.
- Address arithmetic: 32-bit modulo; wraps past 32'hFFFF_FFFF without flagging.
- osram_addr = idx[OSRAM_AW-1:0].

Optional Feature:
- Macro WB_ERR_ABORT_EN.
- Defined:
  - The first icb_rsp_err stops new command issue.
  - A command already presented completes its handshake; the FSM then goes to DRAIN and finishes with done and err = 1.
- Undefined:
  - The transfer runs to completion regardless of errors; err is still sticky.

Decomposition:
- Package mhsa_wb_pkg holds:
  - wb_state_t enum (IDLE, RD, LAT, LO, HI, DRAIN, FIN).
  - BYTES_PER_WORD = 8.
  - ICB_WMASK_FULL = 4'hF.
- No sub-module: the outstanding counter and FSM stay inline.

Test Plan:
- Base 32'h8000_0000, word_cnt 2, osram[0] = 64'h1111_2222_3333_4444, osram[1] = 64'h5555_6666_7777_8888, ready = 1, responses returned 1 cycle after command -> four writes:
  - 8000_0000 = 3333_4444
  - 8000_0004 = 1111_2222
  - 8000_0008 = 7777_8888
  - 8000_000C = 5555_6666
  - then a single done pulse; err = 0.
- word_cnt 0 -> no icb_cmd_valid, no osram_rd_en; done pulses 2 cycles after start.
- Responses withheld, ready = 1, word_cnt 4 -> exactly MAX_OST = 4 commands are issued, then valid deasserts; after responses are released, all 8 writes complete and done fires once.
- icb_cmd_ready held low for 5 cycles during LO -> addr and wdata stable throughout; start pulsed while busy is ignored.
- icb_rsp_err = 1 on the 2nd response, word_cnt 3:
  - With WB_ERR_ABORT_EN: at most 2 + MAX_OST commands, then done with err = 1.
  - Without it: all 6 writes, then done with err = 1.
- rst asserted mid-HI -> all outputs 0 the next cycle and no done; a new start then runs cleanly.
